// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding the FIFO write port through one register stage
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ = 4,
    parameter int MAX_BURST = 4,
    localparam int GW = $clog2(NREQ)
) (
    input  logic                       wclk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ*DATA_WIDTH-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       fifo_full,
    input  logic                       fifo_afull,
    output logic                       fifo_wr_en,
    output logic [DATA_WIDTH-1:0]      fifo_din,
    output logic [GW-1:0]              grant_id,
    output logic                       grant_act
);
    typedef enum logic {IDLE, BURST} state_e;
    state_e                state_q, state_d;
    logic [GW-1:0]         rr_ptr_q, gid_q, win, off, nxt_ptr;
    logic [GW:0]           sum;
    logic [NREQ-1:0]       rot;
    logic [3:0]            beat_cnt_q;
    logic                  wr_en_q, gact_q, space, xfer, done;
    logic [DATA_WIDTH-1:0] din_q, own_data;
    assign space = ~fifo_full & ~(fifo_afull & wr_en_q);
    assign xfer = (state_q == BURST) & ~reset & space & req_valid[gid_q];
    assign done = xfer & (req_last[gid_q] | (beat_cnt_q == 4'(MAX_BURST - 1)));
    assign nxt_ptr = (gid_q == GW'(NREQ - 1)) ? '0 : gid_q + GW'(1);
    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit
    always_comb begin
        rot = NREQ'({req_valid, req_valid} >> rr_ptr_q);
        off = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) off = GW'(k);
        sum = {1'b0, rr_ptr_q} + {1'b0, off};
        win = (sum >= (GW+1)'(NREQ)) ? GW'(sum - (GW+1)'(NREQ)) : sum[GW-1:0];
    end
    // Select the current owner's data slice
    always_comb begin
        own_data = '0;
        for (int k = 0; k < NREQ; k++)
            if (gid_q == GW'(k)) own_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
    // FSM state register
    always_ff @(posedge wclk) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    // FSM next state: one arbitration cycle, then burst until last beat or beat limit
    always_comb begin
        state_d = (state_q == IDLE) ? ((|req_valid) ? BURST : IDLE) : (done ? IDLE : BURST);
    end
    // FSM outputs: only the owner sees ready, gated by FIFO space and reset
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++)
            req_ready[k] = (state_q == BURST) & ~reset & space & (gid_q == GW'(k));
    end
    // Registered write stage, grant bookkeeping and round-robin pointer
    always_ff @(posedge wclk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            gid_q      <= '0;
            gact_q     <= 1'b0;
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            din_q      <= '0;
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                din_q      <= own_data;
                beat_cnt_q <= beat_cnt_q + 4'd1;
            end
            if (state_q == IDLE && |req_valid) begin
                gid_q      <= win;
                gact_q     <= 1'b1;
                beat_cnt_q <= '0;
            end
            if (done) begin
                gact_q   <= 1'b0;
                rr_ptr_q <= nxt_ptr;
            end
        end
    end
    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign grant_id   = gid_q;
    assign grant_act  = gact_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed stimulus with a cycle-level behavioural model and literal checks
module tb_fifo_wr_arbiter;
    localparam int DW = 8, NREQ = 4, MAXB = 4;
    logic        wclk = 0, reset = 1;
    logic [3:0]  req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic        fifo_full = 0, fifo_afull = 0, fifo_wr_en, grant_act;
    logic [7:0]  fifo_din;
    logic [1:0]  grant_id;
    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [7:0]  w_log[$];
    int          w_cyc[$], g_log[$];
    logic        prev_act = 0;
    typedef struct packed {int st; int ptr; int cnt; int gid; bit wr; logic [7:0] din;} mdl_t;
    mdl_t m = '0;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
        .wclk(wclk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_afull(fifo_afull), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .grant_id(grant_id), .grant_act(grant_act));

    always #5 wclk = ~wclk;

    function automatic bit vb(input logic [3:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic logic [3:0] m_ready(input mdl_t c);
        if (reset || c.st == 0 || fifo_full || (fifo_afull && c.wr)) return 4'd0;
        return 4'(1 << c.gid);
    endfunction

    function automatic mdl_t next_m(input mdl_t c);
        mdl_t n;
        bit sp, xf, fnd;
        int w;
        n = c;
        fnd = 0;
        w = 0;
        if (reset) return '0;
        sp = !fifo_full && !(fifo_afull && c.wr);
        xf = c.st == 1 && sp && vb(req_valid, c.gid);
        n.wr = xf;
        if (c.st == 0) begin
            for (int k = 0; k < NREQ; k++)
                if (!fnd && vb(req_valid, (c.ptr + k) % NREQ)) begin
                    fnd = 1;
                    w = (c.ptr + k) % NREQ;
                end
            if (fnd) begin
                n.st = 1;
                n.gid = w;
                n.cnt = 0;
            end
        end else if (xf) begin
            n.din = 8'(req_data >> (c.gid * DW));
            n.cnt = c.cnt + 1;
            if (vb(req_last, c.gid) || n.cnt == MAXB) begin
                n.st = 0;
                n.ptr = (c.gid + 1) % NREQ;
            end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge wclk) begin
        m <= next_m(m);
        cyc <= cyc + 1;
    end

    always @(negedge wclk) begin
        chk("req_ready", 32'(req_ready), 32'(m_ready(m)));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m.wr));
        chk("fifo_din", 32'(fifo_din), 32'(m.din));
        chk("grant_act", 32'(grant_act), m.st);
        chk("grant_id", 32'(grant_id), m.gid);
        if (fifo_wr_en === 1'b1) begin
            w_log.push_back(fifo_din);
            w_cyc.push_back(cyc);
        end
        if (grant_act === 1'b1 && !prev_act) g_log.push_back(int'(grant_id));
        prev_act <= grant_act;
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic set_beat(input int r, input logic [7:0] d, input bit l);
        req_data = (req_data & ~(32'hFF << (r * 8))) | (32'(d) << (r * 8));
        req_last = l ? (req_last | 4'(1 << r)) : (req_last & ~4'(1 << r));
        req_valid = req_valid | 4'(1 << r);
    endtask

    task automatic send(input int r, input logic [7:0] d, input bit l);
        set_beat(r, d, l);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (vb(req_ready, r)) begin
                tick();
                return;
            end
            tick();
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (grant_act === 1'b0 && m.st == 0) return;
            tick();
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        w_log.delete();
        w_cyc.delete();
        g_log.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held with every requester valid
        req_valid = 4'hF;
        req_last = 4'hF;
        repeat (2) tick();
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_act", 32'(grant_act), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_gid", 32'(grant_id), 0);
        clear_logs();
        reset = 0;
        repeat (2) tick();
        req_valid = 0;
        tick();
        wait_idle();
        chk("first_grant", g_log[0], 0);
        // Single three-beat burst from requester 1
        clear_logs();
        req_last = 0;
        send(1, 8'h11, 0);
        send(1, 8'h22, 0);
        send(1, 8'h33, 1);
        chk("burst_act_fall", 32'(grant_act), 0);
        chk("burst_wr_33", 32'(fifo_wr_en), 1);
        chk("burst_din_33", 32'(fifo_din), 32'h33);
        req_valid = 0;
        req_last = 0;
        tick();
        chk("burst_n", w_log.size(), 3);
        chk("burst_d0", 32'(w_log[0]), 32'h11);
        chk("burst_d1", 32'(w_log[1]), 32'h22);
        chk("burst_d2", 32'(w_log[2]), 32'h33);
        chk("burst_back2back", w_cyc[2] - w_cyc[0], 2);
        chk("burst_gid", g_log[0], 1);
        // Round robin of single-beat bursts from a fresh reset
        reset = 1;
        req_valid = 4'hF;
        req_last = 4'hF;
        req_data = 32'h03020100;
        tick();
        clear_logs();
        reset = 0;
        repeat (10) tick();
        req_valid = 0;
        tick();
        wait_idle();
        chk("rr_n", g_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rr_gid", g_log[i], i % 4);
            chk("rr_data", 32'(w_log[i]), i % 4);
        end
        for (int i = 1; i < 5; i++) chk("rr_spacing", w_cyc[i] - w_cyc[i-1], 2);
        // Beat limit forces re-arbitration to the next requester
        clear_logs();
        set_beat(3, 8'hB0, 1);
        send(2, 8'hA0, 0);
        send(2, 8'hA1, 0);
        send(2, 8'hA2, 0);
        send(2, 8'hA3, 0);
        chk("max_act_fall", 32'(grant_act), 0);
        set_beat(2, 8'hA4, 0);
        send(3, 8'hB0, 1);
        req_valid = 0;
        tick();
        wait_idle();
        chk("max_n", w_log.size(), 5);
        chk("max_a0", 32'(w_log[0]), 32'hA0);
        chk("max_a3", 32'(w_log[3]), 32'hA3);
        chk("max_b0", 32'(w_log[4]), 32'hB0);
        chk("max_g0", g_log[0], 2);
        chk("max_g1", g_log[1], 3);
        // Almost-full with a pending write, then a full stall mid-burst
        clear_logs();
        req_last = 0;
        fifo_afull = 1;
        send(0, 8'hC0, 0);
        #1;
        chk("afull_pending_wr", 32'(fifo_wr_en), 1);
        chk("afull_ready", 32'(req_ready), 0);
        send(0, 8'hC1, 0);
        fifo_full = 1;
        set_beat(0, 8'hC2, 0);
        repeat (3) begin
            #1;
            chk("full_ready", 32'(req_ready), 0);
            tick();
        end
        fifo_full = 0;
        fifo_afull = 0;
        send(0, 8'hC2, 0);
        send(0, 8'hC3, 1);
        req_valid = 0;
        tick();
        wait_idle();
        chk("bp_n", w_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("bp_data", 32'(w_log[i]), 32'hC0 + i);
        // Reset during the second beat drops it and clears the pointer
        clear_logs();
        req_last = 0;
        send(1, 8'hD0, 0);
        set_beat(1, 8'hD1, 0);
        reset = 1;
        tick();
        chk("mid_rst_wr_en", 32'(fifo_wr_en), 0);
        chk("mid_rst_act", 32'(grant_act), 0);
        chk("mid_rst_din", 32'(fifo_din), 0);
        chk("mid_rst_ready", 32'(req_ready), 0);
        req_valid = 4'b0101;
        req_last = 4'b0101;
        req_data = 32'h00E200E0;
        reset = 0;
        repeat (2) tick();
        req_valid = 0;
        tick();
        wait_idle();
        chk("mid_rst_n", w_log.size(), 2);
        chk("mid_rst_d0", 32'(w_log[0]), 32'hD0);
        chk("mid_rst_e0", 32'(w_log[1]), 32'hE0);
        chk("mid_rst_ptr", g_log[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
